// File: rtl/snn_input_pingpong.sv
// Double-buffered frame store between a pixel loader and an SNN core.
// The loader fills one bank while the core reads the other; banks swap on fill/release.
//
// bank state | meaning
// -----------+--------------------------------------------------
// EMPTY      | free, loader may start a new frame here
// FILLING    | loader has written at least one word of a frame
// FULL       | complete frame held, waiting for core release
module snn_input_pingpong #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 784,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_vld,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_rdy,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_rdy,
  input  logic              frame_done,
  output logic [1:0]        full_cnt
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_e;

  bank_st_e          bank0_q, bank0_d;
  bank_st_e          bank1_q, bank1_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic             wr_acc;
  logic             wr_last;
  logic             rel;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0_q   <= BANK_EMPTY;
      bank1_q   <= BANK_EMPTY;
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
    end else begin
      bank0_q   <= bank0_d;
      bank1_q   <= bank1_d;
      wr_ptr_q  <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  always_comb begin
    bank0_d   = bank0_q;
    bank1_d   = bank1_q;
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;

    wr_rdy    = wr_bank_q ? (bank1_q != BANK_FULL) : (bank0_q != BANK_FULL);
    frame_rdy = rd_bank_q ? (bank1_q == BANK_FULL) : (bank0_q == BANK_FULL);
    full_cnt  = 2'(bank0_q == BANK_FULL) + 2'(bank1_q == BANK_FULL);

    wr_acc  = wr_vld && wr_rdy;
    wr_last = (wr_ptr_q == IDX_W'(DEPTH - 1));
    rel     = frame_done && frame_rdy;

    if (clr) begin
      bank0_d   = BANK_EMPTY;
      bank1_d   = BANK_EMPTY;
      wr_ptr_d  = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
    end else begin
      if (wr_acc) begin
        if (wr_last) begin
          wr_ptr_d  = '0;
          wr_bank_d = ~wr_bank_q;
        end else begin
          wr_ptr_d = wr_ptr_q + IDX_W'(1);
        end
        if (wr_bank_q) bank1_d = wr_last ? BANK_FULL : BANK_FILLING;
        else           bank0_d = wr_last ? BANK_FULL : BANK_FILLING;
      end
      // A release always hits the FULL read bank, never the bank being written.
      if (rel) begin
        rd_bank_d = ~rd_bank_q;
        if (rd_bank_q) bank1_d = BANK_EMPTY;
        else           bank0_d = BANK_EMPTY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !clr) begin
      if (wr_bank_q) mem1[wr_ptr_q] <= wr_data;
      else           mem0[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign rd_in_range = (32'(rd_addr) < 32'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_in_range) begin
      rd_data_q <= rd_bank_q ? mem1[rd_idx] : mem0[rd_idx];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_snn_input_pingpong.sv
// Bench for snn_input_pingpong: a 784x1 instance driven through full ping-pong
// traffic against a bank model, and an 8x4 instance for clear and range checks.
module tb_snn_input_pingpong;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 784 x 1 instance
  logic       a_clr = 1'b0, a_wr_vld = 1'b0, a_wr_data = 1'b0, a_frame_done = 1'b0;
  logic [9:0] a_rd_addr = '0;
  logic       a_wr_rdy, a_rd_data, a_frame_rdy;
  logic [1:0] a_full_cnt;

  // 8 x 4 instance, wide address so out-of-range reads are reachable
  logic       b_clr = 1'b0, b_wr_vld = 1'b0, b_frame_done = 1'b0;
  logic [3:0] b_wr_data = '0, b_rd_addr = '0;
  logic       b_wr_rdy, b_frame_rdy;
  logic [3:0] b_rd_data;
  logic [1:0] b_full_cnt;

  snn_input_pingpong #(.DATA_W(1), .DEPTH(784)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .wr_vld(a_wr_vld), .wr_data(a_wr_data),
    .wr_rdy(a_wr_rdy), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .frame_rdy(a_frame_rdy), .frame_done(a_frame_done), .full_cnt(a_full_cnt)
  );

  snn_input_pingpong #(.DATA_W(4), .DEPTH(8), .ADDR_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .wr_vld(b_wr_vld), .wr_data(b_wr_data),
    .wr_rdy(b_wr_rdy), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .frame_rdy(b_frame_rdy), .frame_done(b_frame_done), .full_cnt(b_full_cnt)
  );

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] exp_q [$];

  // Behavioural model of the 784-word instance
  bit m_full [2];
  bit m_wb, m_rb;
  int m_wp;
  bit refa [2][784];

  logic [3:0] nb [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic st_a(input string tag, input logic wr, input logic fr, input logic [1:0] cnt);
    chk({tag, ".wr_rdy"},    a_wr_rdy,    wr);
    chk({tag, ".frame_rdy"}, a_frame_rdy, fr);
    chk({tag, ".full_cnt"},  a_full_cnt,  cnt);
  endtask

  task automatic st_b(input string tag, input logic wr, input logic fr, input logic [1:0] cnt);
    chk({tag, ".wr_rdy"},    b_wr_rdy,    wr);
    chk({tag, ".frame_rdy"}, b_frame_rdy, fr);
    chk({tag, ".full_cnt"},  b_full_cnt,  cnt);
  endtask

  task automatic model_reset();
    m_full[0] = 0; m_full[1] = 0;
    m_wb = 0; m_rb = 0; m_wp = 0;
  endtask

  task automatic wr_a(input logic d, input logic fd);
    bit acc, rel;
    acc = !m_full[m_wb];
    rel = fd && m_full[m_rb];
    a_wr_vld = 1'b1; a_wr_data = d; a_frame_done = fd;
    @(negedge clk);
    a_wr_vld = 1'b0; a_frame_done = 1'b0;
    if (acc) begin
      refa[m_wb][m_wp] = d;
      if (m_wp == 783) begin
        m_wp = 0; m_full[m_wb] = 1; m_wb = ~m_wb;
      end else begin
        m_wp++;
      end
    end
    if (rel) begin
      m_full[m_rb] = 0; m_rb = ~m_rb;
    end
  endtask

  task automatic frame_a(input int n, input bit fd_last);
    for (int i = 0; i < n; i++)
      wr_a(1'($urandom_range(0, 1)), fd_last && (i == n - 1));
  endtask

  task automatic fd_a();
    bit rel;
    rel = m_full[m_rb];
    a_frame_done = 1'b1;
    @(negedge clk);
    a_frame_done = 1'b0;
    if (rel) begin
      m_full[m_rb] = 0; m_rb = ~m_rb;
    end
  endtask

  task automatic rd_a(input int k);
    a_rd_addr = 10'(k);
    exp_q.push_back((k < 784) ? 32'(refa[m_rb][k]) : 32'd0);
    @(negedge clk);
    chk($sformatf("rd_a[%0d]", k), a_rd_data, exp_q.pop_front());
  endtask

  task automatic rd_all_a();
    for (int k = 0; k < 784; k++) rd_a(k);
  endtask

  task automatic wr_b(input logic [3:0] d);
    b_wr_vld = 1'b1; b_wr_data = d;
    @(negedge clk);
    b_wr_vld = 1'b0;
  endtask

  task automatic rd_b(input int k, input logic [3:0] e);
    b_rd_addr = 4'(k);
    exp_q.push_back(32'(e));
    @(negedge clk);
    chk($sformatf("rd_b[%0d]", k), b_rd_data, exp_q.pop_front());
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    #1;
    st_a("reset_a", 1'b1, 1'b0, 2'd0);
    chk("reset_a.rd_data", a_rd_data, 0);
    st_b("reset_b", 1'b1, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First frame into B0, then full readback plus out-of-range addresses
    frame_a(783, 0);
    st_a("f0_pre", 1'b1, 1'b0, 2'd0);
    frame_a(1, 0);
    st_a("f0_done", 1'b1, 1'b1, 2'd1);
    rd_all_a();
    rd_a(784);
    rd_a(1023);

    // Second frame with no release: both banks full, loader stalled
    frame_a(784, 0);
    st_a("f1_both_full", 1'b0, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) wr_a(1'($urandom_range(0, 1)), 0);
    st_a("f1_refused", 1'b0, 1'b1, 2'd2);
    fd_a();
    st_a("f1_release", 1'b1, 1'b1, 2'd1);
    rd_all_a();

    // Third frame into B0; release of B1 coincides with its last word
    frame_a(784, 1);
    st_a("f2_coincide", 1'b1, 1'b1, 2'd1);
    rd_all_a();

    // Release with nothing full must not move the read bank
    fd_a();
    st_a("f2_release", 1'b1, 1'b0, 2'd0);
    fd_a();
    st_a("spurious_fd", 1'b1, 1'b0, 2'd0);
    frame_a(784, 0);
    st_a("f3_done", 1'b1, 1'b1, 2'd1);
    rd_a(0);
    rd_a(391);
    rd_a(783);
    fd_a();

    // Reset in the middle of a fill abandons it
    frame_a(300, 0);
    st_a("partial", 1'b1, 1'b0, 2'd0);
    rst_n = 1'b0;
    #1;
    st_a("mid_reset", 1'b1, 1'b0, 2'd0);
    chk("mid_reset.rd_data", a_rd_data, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    frame_a(783, 0);
    st_a("f4_pre", 1'b1, 1'b0, 2'd0);
    frame_a(1, 0);
    st_a("f4_done", 1'b1, 1'b1, 2'd1);
    rd_all_a();

    // Small instance: clear with one full bank and wr_ptr at 3
    for (int i = 0; i < 8; i++) wr_b(4'(i + 3));
    st_b("b_full", 1'b1, 1'b1, 2'd1);
    wr_b(4'hA); wr_b(4'hB); wr_b(4'hC);
    rd_b(5, 4'd8);
    b_rd_addr = 4'd9;
    b_clr = 1'b1; b_wr_vld = 1'b1; b_wr_data = 4'hF; b_frame_done = 1'b1;
    @(negedge clk);
    b_clr = 1'b0; b_wr_vld = 1'b0; b_frame_done = 1'b0;
    st_b("b_clr", 1'b1, 1'b0, 2'd0);
    chk("b_clr.rd_data", b_rd_data, 0);
    rd_b(9, 4'd0);
    for (int i = 0; i < 8; i++) nb[i] = 4'(i * 3 + 1);
    for (int i = 0; i < 7; i++) wr_b(nb[i]);
    st_b("b_refill_pre", 1'b1, 1'b0, 2'd0);
    wr_b(nb[7]);
    st_b("b_refill", 1'b1, 1'b1, 2'd1);
    for (int k = 0; k < 8; k++) rd_b(k, nb[k]);
    rd_b(8, 4'd0);
    rd_b(15, 4'd0);
    b_frame_done = 1'b1;
    @(negedge clk);
    b_frame_done = 1'b0;
    st_b("b_release", 1'b1, 1'b0, 2'd0);
    // B1 kept its words across the clear even though it is now EMPTY
    rd_b(1, 4'hB);
    rd_b(2, 4'hC);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_input_pingpong.md
SNN_INPUT_PINGPONG -- requirements
Module: snn_input_pingpong

Interface
REQ-001 SHALL have parameter DATA_W, default 1: pixel word width in bits.
REQ-002 SHALL have parameter DEPTH, default 784: words per frame; ADDR_W = ceil(log2(DEPTH)), default 10.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous flush of all frame state.
REQ-006 SHALL have port wr_vld  input  1  loader word valid.
REQ-007 SHALL have port wr_data  input  DATA_W  loader pixel word.
REQ-008 SHALL have port wr_rdy  output  1  buffer can accept a word this cycle.
REQ-009 SHALL have port rd_addr  input  ADDR_W  core read address.
REQ-010 SHALL have port rd_data  output  DATA_W  registered read word.
REQ-011 SHALL have port frame_rdy  output  1  complete frame available in the read bank.
REQ-012 SHALL have port frame_done  input  1  single-cycle pulse from the core that releases the read bank.
REQ-013 SHALL have port full_cnt  output  2  number of FULL banks (0..2).

Function
REQ-014 SHALL contain two storage banks, B0 and B1, each DEPTH x DATA_W.
REQ-015 SHALL hold a write pointer wr_ptr, a write-bank select wr_bank and a read-bank select rd_bank.
REQ-016 SHALL give each bank the states EMPTY, FILLING and FULL.
REQ-017 SHALL move a bank EMPTY->FILLING on its first accepted word, FILLING->FULL on the accept at wr_ptr=DEPTH-1, and FULL->EMPTY on release.
REQ-018 SHALL drive wr_rdy = 1 exactly when bank[wr_bank] is not FULL (combinational).
REQ-019 SHALL, on accept (wr_vld && wr_rdy), write wr_data to bank[wr_bank][wr_ptr] and increment wr_ptr.
REQ-020 SHALL, on the accept at wr_ptr=DEPTH-1, wrap wr_ptr to 0, mark the bank FULL and toggle wr_bank in that same edge.
REQ-021 SHALL ignore wr_vld while wr_rdy=0: no write, no pointer change, no data loss beyond the refused word.
REQ-022 SHALL drive frame_rdy = 1 exactly when bank[rd_bank] is FULL.
REQ-023 SHALL, when frame_done=1 and frame_rdy=1, mark bank[rd_bank] EMPTY and toggle rd_bank on the next edge.
REQ-024 SHALL ignore frame_done while frame_rdy=0.
REQ-025 SHALL apply both updates in the same edge when a frame-completing write and a valid frame_done coincide; they target different banks by construction.
REQ-026 SHALL compute rd_data, with 1-cycle latency, as the word of bank[rd_bank] at the rd_addr sampled in cycle N, presented in cycle N+1.
REQ-027 SHALL use the rd_bank value sampled with the address for the read.
REQ-028 SHALL return rd_data = 0 for a sampled rd_addr >= DEPTH.
REQ-029 SHALL return the stored contents unchanged for any read while frame_rdy=0; the core reads only while frame_rdy=1.
REQ-030 SHALL allow the loader to refill a released bank while the core reads the other bank; full throughput of one word per cycle SHALL be sustained.
REQ-031 SHALL derive full_cnt from the bank states and update it in the same edge as any state change.
REQ-032 SHALL, on clr=1, set wr_ptr=0, wr_bank=0, rd_bank=0 and both banks EMPTY.
REQ-033 SHALL give clr priority over a simultaneous write or frame_done.
REQ-034 SHALL leave memory contents and rd_data unaffected by clr.

Reset
REQ-035 SHALL, on rst_n=0, asynchronously set wr_ptr=0, wr_bank=0, rd_bank=0, both banks EMPTY and rd_data=0.
REQ-036 SHALL therefore present after reset: wr_rdy=1, frame_rdy=0, full_cnt=0.
REQ-037 SHALL not require a memory array reset.
REQ-038 SHALL abandon a partially filled frame on reset mid-fill; the next accepted word goes to B0[0].

Verification (DATA_W=1, DEPTH=784 unless noted)
REQ-039 SHALL cover: reset, then 784 accepts of pattern p -> frame_rdy=1 on the edge after the last accept; full_cnt=1; rd_addr=k returns p[k] one cycle later for all k.
REQ-040 SHALL cover: 1568 back-to-back words with no frame_done -> wr_rdy=0 after word 1568, full_cnt=2; further wr_vld is refused; after frame_done, wr_rdy=1 and the next word lands in B0[0].
REQ-041 SHALL cover: frame_done in the same cycle as the 784th write of the second frame -> rd_bank=1, frame_rdy=1, full_cnt=1, with no word lost.
REQ-042 SHALL cover: frame_done pulsed with frame_rdy=0 -> no state change.
REQ-043 SHALL cover: rst_n low after 300 words -> outputs at reset values; a new 784-word frame reads back correctly from address 0.
REQ-044 SHALL cover: DEPTH=8, DATA_W=4, clr asserted with full_cnt=1 and wr_ptr=3 -> full_cnt=0, wr_rdy=1, frame_rdy=0; rd_addr=9 returns 0.
